// File: rtl/regfile_2r1w_if.sv
// Decoder-side bus for regfile_2r1w: write port, shared-enable dual read port,
// clear request and busy status.
interface regfile_2r1w_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] din;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    rsel_a;
    logic [AW-1:0]    rsel_b;
    logic [WIDTH-1:0] outa;
    logic [WIDTH-1:0] outb;
    logic             clr;
    logic             busy;

    modport master (
        output din, we, waddr, wdata, re, rsel_a, rsel_b, clr,
        input  outa, outb, busy
    );

    modport slave (
        input  din, we, waddr, wdata, re, rsel_a, rsel_b, clr,
        output outa, outb, busy
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file with one write port, two registered read ports and a clear sweep.
// Address 0 reads the external din bus. Define REGFILE_BYPASS_EN for write-first forwarding.
module regfile_2r1w #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic          clk,
    input logic          rst,
    regfile_2r1w_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int NPORT = 2;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                        state;
    logic [AW-1:0]                 ptr;
    logic                          busy_q;
    logic [DEPTH-1:1][WIDTH-1:0]   mem;
    logic                          wr_acc;
    logic [NPORT-1:0][AW-1:0]      rsel;
    logic [NPORT-1:0][WIDTH-1:0]   rd_q;

    // A clear request in IDLE takes priority over a same-edge write.
    assign wr_acc = bus.we && (bus.waddr != '0) && (state == IDLE) && !bus.clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        state  <= CLEAR;
                        ptr    <= AW'(1);
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_acc) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    assign rsel = {bus.rsel_b, bus.rsel_a};

    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        logic [WIDTH-1:0] rd_d;
        logic [WIDTH-1:0] q;

        always_comb begin
            rd_d = bus.din;
            if (rsel[p] != '0) rd_d = mem[rsel[p]];
`ifdef REGFILE_BYPASS_EN
            // wr_acc already excludes address 0 and writes dropped by the sweep.
            if (wr_acc && (rsel[p] == bus.waddr)) rd_d = bus.wdata;
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)         q <= '0;
            else if (bus.re) q <= rd_d;
        end

        assign rd_q[p] = q;
    end

    assign bus.outa = rd_q[0];
    assign bus.outb = rd_q[1];
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w (WIDTH=16, DEPTH=8): vector table plus
// hand-written clear-sweep and reset sequences.
module tb_regfile_2r1w;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    regfile_2r1w_if #(.WIDTH(16), .DEPTH(8)) bus ();

    regfile_2r1w #(.WIDTH(16), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam logic [15:0] COL = 16'h2222;
`else
    localparam logic [15:0] COL = 16'h1111;
`endif

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        re;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] din;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic we, logic [2:0] wa, logic [15:0] wd, logic re,
                                logic [2:0] ra, logic [2:0] rb, logic [15:0] din,
                                logic [15:0] ea, logic [15:0] eb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.rb = rb;
        v.din = din; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(logic we, logic [2:0] wa, logic [15:0] wd, logic re,
                       logic [2:0] ra, logic [2:0] rb, logic [15:0] din, logic clr);
        bus.we = we; bus.waddr = wa; bus.wdata = wd; bus.re = re;
        bus.rsel_a = ra; bus.rsel_b = rb; bus.din = din; bus.clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0);
    endtask

    initial begin
        int n;
        tbl[0]  = mk(0, 0, 16'h0,    1, 1, 2, 16'h0,    16'h0,    16'h0);
        tbl[1]  = mk(0, 0, 16'h0,    1, 3, 4, 16'h0,    16'h0,    16'h0);
        tbl[2]  = mk(0, 0, 16'h0,    1, 5, 6, 16'h0,    16'h0,    16'h0);
        tbl[3]  = mk(0, 0, 16'h0,    1, 7, 7, 16'h0,    16'h0,    16'h0);
        tbl[4]  = mk(1, 3, 16'hA5A5, 0, 0, 0, 16'h0,    16'h0,    16'h0);
        tbl[5]  = mk(0, 0, 16'h0,    1, 3, 0, 16'h1234, 16'hA5A5, 16'h1234);
        tbl[6]  = mk(1, 0, 16'hFFFF, 1, 0, 3, 16'h0001, 16'h0001, 16'hA5A5);
        tbl[7]  = mk(0, 0, 16'h0,    1, 1, 2, 16'h0001, 16'h0,    16'h0);
        tbl[8]  = mk(0, 0, 16'h0,    1, 4, 5, 16'h0001, 16'h0,    16'h0);
        tbl[9]  = mk(0, 0, 16'h0,    1, 6, 7, 16'h0001, 16'h0,    16'h0);
        tbl[10] = mk(0, 0, 16'h0,    1, 3, 0, 16'h0001, 16'hA5A5, 16'h0001);
        tbl[11] = mk(0, 0, 16'h0,    0, 1, 1, 16'h5555, 16'hA5A5, 16'h0001);
        tbl[12] = mk(1, 5, 16'h1111, 0, 0, 0, 16'h0,    16'hA5A5, 16'h0001);
        tbl[13] = mk(1, 5, 16'h2222, 1, 5, 5, 16'h0,    COL,      COL);
        tbl[14] = mk(0, 0, 16'h0,    1, 5, 5, 16'h0,    16'h2222, 16'h2222);
        tbl[15] = mk(1, 6, 16'h6666, 0, 0, 0, 16'h0,    16'h2222, 16'h2222);
        tbl[16] = mk(0, 0, 16'h0,    1, 6, 5, 16'h0,    16'h6666, 16'h2222);

        bus.we = 0; bus.waddr = 0; bus.wdata = 0; bus.re = 0;
        bus.rsel_a = 0; bus.rsel_b = 0; bus.din = 0; bus.clr = 0;
        #2;
        chk("reset outa", bus.outa, 16'h0);
        chk("reset outb", bus.outb, 16'h0);
        chk("reset busy", 16'(bus.busy), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].rb, tbl[i].din, 1'b0);
            chk($sformatf("vec%0d outa", i), bus.outa, tbl[i].ea);
            chk($sformatf("vec%0d outb", i), bus.outb, tbl[i].eb);
            chk($sformatf("vec%0d busy", i), 16'(bus.busy), 16'h0);
        end

        // Sweep A: fill, clear, mid-sweep reads see pre-edge contents.
        for (int i = 1; i < 8; i++) cyc(1, 3'(i), 16'(16'h0101 * i), 0, 0, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 0, 0, 0, 16'h0, 1);
        chk("A busy k0", 16'(bus.busy), 16'h1);
        for (int k = 1; k < 8; k++) begin
            if (k == 1)      cyc(0, 0, 16'h0, 1, 7, 1, 16'h0, 0);
            else if (k == 2) cyc(0, 0, 16'h0, 1, 1, 7, 16'h0, 0);
            else             idle();
            chk($sformatf("A busy k%0d", k), 16'(bus.busy), (k < 7) ? 16'h1 : 16'h0);
            if (k == 1) begin
                chk("A mid reg7", bus.outa, 16'h0707);
                chk("A mid reg1", bus.outb, 16'h0101);
            end
            if (k == 2) begin
                chk("A cleared reg1", bus.outa, 16'h0);
                chk("A mid reg7 b", bus.outb, 16'h0707);
            end
        end
        for (int i = 1; i < 8; i += 2) begin
            cyc(0, 0, 16'h0, 1, 3'(i), 3'((i + 1) % 8), 16'hCAFE, 0);
            chk($sformatf("A post r%0d", i), bus.outa, 16'h0);
            chk($sformatf("A post r%0d", (i + 1) % 8), bus.outb, (i == 7) ? 16'hCAFE : 16'h0);
        end

        // Sweep B: CLR beats WE, busy writes lost, second CLR ignored.
        cyc(1, 2, 16'hBEEF, 1, 2, 2, 16'h0, 1);
        chk("B busy k0", 16'(bus.busy), 16'h1);
        chk("B no fwd a", bus.outa, 16'h0);
        chk("B no fwd b", bus.outb, 16'h0);
        for (int k = 1; k < 8; k++) begin
            if (k == 2)      cyc(1, 4, 16'h4444, 1, 4, 4, 16'h0, 0);
            else if (k == 3) cyc(0, 0, 16'h0, 0, 0, 0, 16'h0, 1);
            else             idle();
            chk($sformatf("B busy k%0d", k), 16'(bus.busy), (k < 7) ? 16'h1 : 16'h0);
            if (k == 2) chk("B busy wr no fwd", bus.outa, 16'h0);
        end
        cyc(1, 3, 16'h3333, 0, 0, 0, 16'h0, 0);
        chk("B busy after", 16'(bus.busy), 16'h0);
        cyc(0, 0, 16'h0, 1, 2, 4, 16'h0, 0);
        chk("B reg2", bus.outa, 16'h0);
        chk("B reg4", bus.outb, 16'h0);
        cyc(0, 0, 16'h0, 1, 3, 3, 16'h0, 0);
        chk("B first write", bus.outa, 16'h3333);

        // Sweep C: reset on third sweep cycle, then a full fresh sweep.
        cyc(1, 7, 16'h7777, 0, 0, 0, 16'h0, 0);
        cyc(1, 1, 16'h1111, 0, 0, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 1, 7, 1, 16'h0, 0);
        chk("C pre a", bus.outa, 16'h7777);
        chk("C pre b", bus.outb, 16'h1111);
        cyc(0, 0, 16'h0, 0, 0, 0, 16'h0, 1);
        idle();
        idle();
        rst = 1'b1;
        #1;
        chk("C rst busy", 16'(bus.busy), 16'h0);
        chk("C rst outa", bus.outa, 16'h0);
        chk("C rst outb", bus.outb, 16'h0);
        #2;
        rst = 1'b0;
        cyc(0, 0, 16'h0, 1, 7, 1, 16'h0, 0);
        chk("C reg7", bus.outa, 16'h0);
        chk("C reg1", bus.outb, 16'h0);
        cyc(0, 0, 16'h0, 1, 3, 2, 16'h0, 0);
        chk("C reg3", bus.outa, 16'h0);
        chk("C reg2", bus.outb, 16'h0);
        cyc(0, 0, 16'h0, 0, 0, 0, 16'h0, 1);
        n = 0;
        if (bus.busy) n = 1;
        for (int k = 0; k < 20 && bus.busy; k++) begin
            idle();
            if (bus.busy) n++;
        end
        chk("C sweep len", 16'(n), 16'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
